seq_shifter: RTL and testbench

Multi-cycle sequential shifter: accepts an 8-bit operand and a shift command, then shifts one bit position per clock until the requested amount is reached. It is the time-multiplexed counterpart of the combinational mux-tree barrel shifter. It serves as the low-area shift unit for datapaths that can tolerate variable latency. Operation is controlled by a start/busy/done handshake, and the result is held on `dout` until the next command completes.

---
 rtl/seq_shifter.sv | 148 ++++++++++++++
 tb/tb_seq_shifter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter -- multi-cycle sequential shifter.
//
// Takes a WIDTH-bit operand plus a shift command and moves the operand one
// bit position per clock until the requested amount has been applied. It is
// the small, variable-latency alternative to a combinational barrel shifter.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst    : synchronous active-high reset (priority over everything)
//   start  : command request, accepted only while ready
//   din    : operand, sampled on the accepting edge
//   shamt  : shift amount 0..WIDTH-1, sampled on the accepting edge
//   LR     : direction, 0 = right, 1 = left
//   AL     : 1 = arithmetic fill (right shifts only), 0 = logical
//   ROT    : 1 = rotate, overrides AL
//   ready  : high while idle
//   busy   : high from acceptance through the done cycle
//   done   : one-cycle pulse in the cycle dout first shows a new result
//   dout   : result register, held between commands
//
// Latency for shamt = N is N+2 cycles. The cycle after acceptance starts the
// step loop, N cycles shift, one more cycle copies the result to dout, and
// that copy edge is also the DONE-entry edge.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             LR,
  input  logic             AL,
  input  logic             ROT,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Mode bits are latched at acceptance, so later input changes cannot
  // disturb a command that is already running.
  typedef struct packed {
    logic lr;
    logic al;
    logic rot;
  } mode_t;

  state_t           state;
  mode_t            mode;
  logic [WIDTH-1:0] data;
  logic [SHW-1:0]   cnt;

  // Single-step datapath: each bit takes either its lower neighbour (left
  // shift) or its upper neighbour (right shift). The two end bits take the
  // fill bits instead.
  logic             fill_msb;
  logic             fill_lsb;
  logic [WIDTH-1:0] from_lo;
  logic [WIDTH-1:0] from_hi;
  logic [WIDTH-1:0] data_step;

  always_comb begin
    fill_msb = 1'b0;
    if (mode.rot)      fill_msb = data[0];
    else if (mode.al)  fill_msb = data[WIDTH-1];
  end

  // A left shift never sign-fills, so AL plays no part here.
  assign fill_lsb = mode.rot ? data[WIDTH-1] : 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lo_end
      assign from_lo[i] = fill_lsb;
    end else begin : g_lo_mid
      assign from_lo[i] = data[i-1];
    end

    if (i == WIDTH-1) begin : g_hi_end
      assign from_hi[i] = fill_msb;
    end else begin : g_hi_mid
      assign from_hi[i] = data[i+1];
    end

    assign data_step[i] = mode.lr ? from_lo[i] : from_hi[i];
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode  <= '0;
      data  <= '0;
      cnt   <= '0;
      dout  <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data  <= din;
            cnt   <= shamt;
            mode  <= '{lr: LR, al: AL, rot: ROT};
            state <= SHIFT;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end

        SHIFT: begin
          if (cnt != '0) begin
            data <= data_step;
            cnt  <= cnt - 1'b1;
          end else begin
            // dout only moves here; done rises with it.
            dout  <= data;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          // Any start seen here or during SHIFT is dropped, not queued.
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter. The driver pushes the expected result and
// the expected done cycle for each command. The monitor pops one entry on
// every done pulse and also checks that dout holds steady in every other
// cycle.
module tb_seq_shifter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] din = '0;
  logic [2:0]   shamt = '0;
  logic         LR = 1'b0, AL = 1'b0, ROT = 1'b0;
  logic         ready, busy, done;
  logic [W-1:0] dout;

  seq_shifter #(.WIDTH(W), .SHW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .shamt(shamt),
    .LR(LR), .AL(AL), .ROT(ROT),
    .ready(ready), .busy(busy), .done(done), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] v;
    int           cyc;
  } sb_t;

  sb_t          sb[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_err = 0;
  int           last_acc = 0;
  logic [W-1:0] exp_dout = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the whole shift done in one go with plain operators.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int n,
                                             input logic lr, input logic al,
                                             input logic rot);
    logic [2*W-1:0] w;
    logic [W-1:0]   r;
    w = {d, d};
    if (rot)      r = lr ? w[2*W-1-n -: W] : w[n +: W];
    else if (lr)  r = d << n;
    else if (al)  r = W'($signed(d) >>> n);
    else          r = d >> n;
    return r;
  endfunction

  // A reset edge throws away anything in flight.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      exp_dout = '0;
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      n_chk++;
      if (done) begin
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL spurious_done: done=1 at cycle %0d with nothing expected", cyc);
        end else begin
          e = sb.pop_front();
          if (dout !== e.v || cyc != e.cyc) begin
            n_err++;
            $display("FAIL result: dout=%h cycle=%0d, want dout=%h cycle=%0d",
                     dout, cyc, e.v, e.cyc);
          end
          exp_dout = e.v;
        end
      end else if (dout !== exp_dout) begin
        n_err++;
        $display("FAIL dout_hold: dout=%h at cycle %0d, want %h", dout, cyc, exp_dout);
      end
    end
  end

  // Called at a negedge. hold = extra cycles start stays high before the
  // expected acceptance; exp_k < 0 means take the expectation from the model.
  task automatic issue(input logic [W-1:0] d, input int n, input logic lr,
                       input logic al, input logic rot, input int hold,
                       input bit poke, input bit wait_rdy, input int exp_k);
    sb_t e;
    int  t;
    start = 1'b1; din = d; shamt = 3'(n); LR = lr; AL = al; ROT = rot;
    last_acc = cyc + hold;
    e.v   = (exp_k < 0) ? ref_shift(d, n, lr, al, rot) : W'(exp_k);
    e.cyc = last_acc + n + 2;
    sb.push_back(e);
    repeat (hold + 1) @(negedge clk);
    // Scramble the inputs so any late sampling shows up as a bad result.
    start = 1'b0; din = W'($urandom); shamt = 3'($urandom);
    LR = 1'($urandom); AL = 1'($urandom); ROT = 1'($urandom);
    if (poke) begin
      start = 1'b1; din = 8'hFF; shamt = 3'd0;
      @(negedge clk);
      start = 1'b0;
    end
    if (wait_rdy) begin
      t = 0;
      while (!ready && t < 40) begin
        @(negedge clk);
        t++;
      end
      n_chk++;
      if (ready !== 1'b1 || cyc != last_acc + n + 3) begin
        n_err++;
        $display("FAIL ready_return: ready=%b at cycle %0d, want 1 at cycle %0d",
                 ready, cyc, last_acc + n + 3);
      end
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  initial begin
    int c;
    // Reset with start high: nothing must be accepted.
    rst = 1'b1; start = 1'b1; din = 8'h5A; shamt = 3'd1;
    repeat (2) @(negedge clk);
    chk("reset_dout",  dout, 8'h00);
    chk("reset_ready", W'(ready), 8'h01);
    chk("reset_busy",  W'(busy),  8'h00);
    chk("reset_done",  W'(done),  8'h00);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    issue(8'h96, 3, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 'hF2);
    issue(8'h96, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 'h12);
    issue(8'h96, 2, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 'h58);
    issue(8'h96, 2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 'h58);
    issue(8'h96, 1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 'h4B);
    issue(8'h96, 3, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 'hB4);
    issue(8'h96, 7, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 'h2D);
    issue(8'hA5, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 'hA5);
    // start re-pulsed with 0xFF while busy must be ignored.
    issue(8'h3C, 4, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 'hC0);

    // Back-to-back: second start held from cycle N+2, taken at end of N+3.
    c = cyc;
    issue(8'h96, 3, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 'hF2);
    while (cyc < c + 3 + 2) @(negedge clk);
    issue(8'h81, 1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 'hC0);

    // Mid-command reset: no done, dout cleared, then a normal command.
    c = cyc;
    issue(8'h96, 5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1);
    while (cyc < c + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_dout",  dout, 8'h00);
    chk("abort_ready", W'(ready), 8'h01);
    chk("abort_done",  W'(done),  8'h00);
    repeat (10) @(negedge clk);
    issue(8'h96, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 'h4B);

    // Random commands, occasionally poked while busy.
    for (int i = 0; i < 60; i++) begin
      issue(W'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            1'($urandom), 0, 1'($urandom_range(0, 3) == 0), 1'b1, -1);
    end

    repeat (5) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results still expected, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: bench still running at cycle %0d, want finished", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
